serial_ram_master: RTL and testbench
====================================

SERIAL_RAM_MASTER -- requirements
Module: serial_ram_master

Interface
REQ-001 Parameter DELAY, default 7: idle cycles between the last address nibble and the first data nibble; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  read request; accepted when req && ready at a rising edge.
REQ-005 req_addr  input  16  word address, sampled on acceptance.
REQ-006 ready  output  1  high only in IDLE; new request may be accepted.
REQ-007 rsp_valid  output  1  one-cycle pulse; rsp_data valid.
REQ-008 rsp_data  output  16  read word; holds value until next rsp_valid.
REQ-009 addr_pins  output  4  serial address bus to external RAM, registered.
REQ-010 data_pins  input  4  serial data bus from external RAM.

Function
REQ-011 States IDLE, START, ADDR, WAIT, DATA, RESP; IDLE on reset.
REQ-012 In IDLE, addr_pins SHALL be 4'b0000; an accepted request SHALL move to START and latch req_addr.
REQ-013 Cycle S (START): addr_pins = 4'b0001 (start marker), ready low.
REQ-014 Cycles S+1..S+4 (ADDR): addr_pins = req_addr[3:0], [7:4], [11:8], [15:12], in that order.
REQ-015 Cycles S+5..S+4+DELAY (WAIT): addr_pins = 4'b0000; WAIT skipped when DELAY=0.
REQ-016 Cycles S+5+DELAY..S+8+DELAY (DATA): data_pins sampled at end of each cycle into rsp_data[3:0], [7:4], [11:8], [15:12] respectively; addr_pins = 4'b0000.
REQ-017 Cycle S+9+DELAY (RESP): rsp_valid = 1, rsp_data complete, ready = 1 (state IDLE-equivalent; a req in this cycle is accepted, next START at S+10+DELAY).
REQ-018 Total request-to-response latency: acceptance edge E -> rsp_valid in cycle E+10+DELAY (cycle after E is S).
REQ-019 req while ready low SHALL be ignored, no queueing; req_addr changes after acceptance SHALL not affect the transaction.
REQ-020 Nibble and wait counters SHALL be 4-bit; no wrap beyond the ranges above.
REQ-021 rsp_data SHALL update only on the final DATA sample; intermediate nibbles held in a shift/assembly register not visible on rsp_data.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, ready 1, rsp_valid 0, rsp_data 16'h0000, addr_pins 4'b0000, counters 0.
REQ-023 Reset asserted mid-transaction SHALL abandon it; no rsp_valid for it after release.
REQ-024 First request after reset release accepted at the first rising edge with rst_n high and req high.

Configuration
REQ-025 Macro SERIAL_RAM_MASTER_IN_REG_EN: when defined, data_pins SHALL pass through one input register before sampling; DATA window and RESP shift one cycle later (rsp_valid at E+11+DELAY); input register reset to 0.
REQ-026 Without SERIAL_RAM_MASTER_IN_REG_EN, data_pins SHALL be sampled directly per REQ-016; no extra register.

Verification
REQ-027 DELAY=7, req_addr=16'h1234 accepted at E -> addr_pins 1,4,3,2,1 on cycles E+1..E+5, then 0; RAM model returns nibbles F,E,E,B -> rsp_valid at E+17, rsp_data=16'hBEEF.
REQ-028 DELAY=0, req_addr=16'hFFFF, model nibbles 0,0,0,0 -> no WAIT cycles, rsp_valid at E+10, rsp_data=16'h0000, addr_pins never 4'b0001 except at S.
REQ-029 req held high continuously, addresses 16'h0001 then 16'h0002 -> second START exactly one cycle after first rsp_valid; req pulses during busy ignored; ready low throughout each transaction.
REQ-030 rst_n pulsed low during WAIT of a 16'hABCD read -> outputs at reset values within the reset pulse, no rsp_valid afterwards; next 16'h0010 read completes correctly.
REQ-031 SERIAL_RAM_MASTER_IN_REG_EN defined, DELAY=7, model delay +1 -> rsp_valid at E+18 with correct word; undefined build passes REQ-027 unchanged.

Source files
------------

// File: rtl/serial_ram_master.sv
// Read master for a nibble-serial external RAM: start marker, 4 address nibbles, DELAY idle cycles, 4 data nibbles.
// Optional SERIAL_RAM_MASTER_IN_REG_EN registers data_pins once, pushing the DATA window and response one cycle later.
module serial_ram_master #(
    parameter int unsigned DELAY = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] req_addr,
    output logic        ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [3:0]  addr_pins,
    input  logic [3:0]  data_pins
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_RESP
    } state_t;

    logic [3:0] sample_nib;

`ifdef SERIAL_RAM_MASTER_IN_REG_EN
    localparam int unsigned WAIT_LEN = DELAY + 1;

    logic [3:0] din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= 4'h0;
        else        din_q <= data_pins;
    end

    assign sample_nib = din_q;
`else
    localparam int unsigned WAIT_LEN = DELAY;

    assign sample_nib = data_pins;
`endif

    // Value of the wait counter in the last WAIT cycle; unused when WAIT is skipped.
    localparam logic [3:0] WAIT_LAST = (WAIT_LEN == 0) ? 4'd0 : 4'(WAIT_LEN - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  addr_pins_d;
    logic [15:0] addr_q;
    logic [11:0] shift_q;
    logic [1:0]  nib_idx;
    logic        accept;

    assign ready     = (state_q == S_IDLE) || (state_q == S_RESP);
    assign rsp_valid = (state_q == S_RESP);
    assign accept    = req && ready;
    assign nib_idx   = cnt_q[1:0] + 2'd1;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_pins_d = 4'b0000;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d     = S_START;
                    addr_pins_d = 4'b0001;
                end else begin
                    state_d = S_IDLE;
                end
                cnt_d = 4'd0;
            end
            S_START: begin
                state_d     = S_ADDR;
                cnt_d       = 4'd0;
                addr_pins_d = addr_q[3:0];
            end
            S_ADDR: begin
                if (cnt_q == 4'd3) begin
                    state_d = (WAIT_LEN == 0) ? S_DATA : S_WAIT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    addr_pins_d = addr_q[{nib_idx, 2'b00} +: 4];
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 4'd3) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_pins <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_pins <= addr_pins_d;
        end
    end

    // Nibbles assemble in shift_q; rsp_data only changes on the fourth sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 16'h0000;
            shift_q  <= 12'h000;
            rsp_data <= 16'h0000;
        end else begin
            if (accept) addr_q <= req_addr;
            if (state_q == S_DATA) begin
                shift_q <= {sample_nib, shift_q[11:4]};
                if (cnt_q == 4'd3) rsp_data <= {sample_nib, shift_q};
            end
        end
    end

endmodule

// File: tb/tb_serial_ram_master.sv
// Directed bench for serial_ram_master: two instances (DELAY=7 and DELAY=0) driven by a cycle-exact RAM model.
// Honours SERIAL_RAM_MASTER_IN_REG_EN by expecting the response one cycle later.
module tb_serial_ram_master;

`ifdef SERIAL_RAM_MASTER_IN_REG_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req7 = 1'b0, req0 = 1'b0;
    logic [15:0] addr7 = 16'h0, addr0 = 16'h0;
    logic [3:0]  dp7 = 4'h0, dp0 = 4'h0;
    logic        rdy7, rdy0, rv7, rv0;
    logic [15:0] rd7, rd0;
    logic [3:0]  ap7, ap0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_ram_master #(.DELAY(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .req(req7), .req_addr(addr7), .ready(rdy7),
        .rsp_valid(rv7), .rsp_data(rd7), .addr_pins(ap7), .data_pins(dp7)
    );

    serial_ram_master #(.DELAY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .req_addr(addr0), .ready(rdy0),
        .rsp_valid(rv0), .rsp_data(rd0), .addr_pins(ap0), .data_pins(dp0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one read on the instance with delay d. Caller has req/addr set at a negedge before edge E.
    // keep holds req high and presents a_next so the next read is accepted in the RESP cycle.
    // Returns at the negedge of the RESP cycle.
    task automatic txn(input int d, input logic [15:0] a, input logic [15:0] w,
                       input bit keep, input logic [15:0] a_next, input string tag);
        int          lat;
        logic [15:0] prev;
        logic [3:0]  nib, exp_ap;
        logic        o_rdy, o_rv, n_req;
        logic [15:0] o_rd, n_addr;
        logic [3:0]  o_ap;
        lat  = 10 + d + XTRA;
        prev = (d == 7) ? rd7 : rd0;
        check({tag, " ready_at_accept"}, (d == 7) ? rdy7 : rdy0, 1);
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            #1;
            nib = 4'h5;
            if (c >= 6 + d && c <= 9 + d) nib = w[(c - 6 - d) * 4 +: 4];
            n_addr = (d == 7) ? addr7 : addr0;
            if (keep) begin
                n_req = 1'b1;
                if (c == 1) n_addr = a_next;
            end else begin
                n_req = (c == 3 || c == 8) && (c < lat);
                if (c == 1) n_addr = ~a;
            end
            if (d == 7) begin
                dp7 = nib; req7 = n_req; addr7 = n_addr;
            end else begin
                dp0 = nib; req0 = n_req; addr0 = n_addr;
            end
            @(negedge clk);
            if (d == 7) begin
                o_rdy = rdy7; o_rv = rv7; o_rd = rd7; o_ap = ap7;
            end else begin
                o_rdy = rdy0; o_rv = rv0; o_rd = rd0; o_ap = ap0;
            end
            exp_ap = 4'h0;
            if (c == 1) exp_ap = 4'h1;
            else if (c >= 2 && c <= 5) exp_ap = a[(c - 2) * 4 +: 4];
            check($sformatf("%s c%0d addr_pins", tag, c), o_ap, exp_ap);
            check($sformatf("%s c%0d rsp_valid", tag, c), o_rv, (c == lat) ? 1 : 0);
            check($sformatf("%s c%0d ready", tag, c), o_rdy, (c == lat) ? 1 : 0);
            check($sformatf("%s c%0d rsp_data", tag, c), o_rd, (c == lat) ? w : prev);
            if (c < lat) @(posedge clk);
        end
    endtask

    initial begin
        bit saw;

        #2;
        check("reset ready7", rdy7, 1);
        check("reset rsp_valid7", rv7, 0);
        check("reset rsp_data7", rd7, 16'h0000);
        check("reset addr_pins7", ap7, 4'h0);
        check("reset ready0", rdy0, 1);
        check("reset addr_pins0", ap0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First request accepted on the first edge after release.
        req7 = 1'b1; addr7 = 16'h1234;
        txn(7, 16'h1234, 16'hBEEF, 1'b0, 16'h0, "d7_1234");
        @(posedge clk); @(negedge clk);
        check("d7 idle rsp_valid", rv7, 0);
        check("d7 idle ready", rdy7, 1);
        check("d7 idle rsp_data hold", rd7, 16'hBEEF);
        check("d7 idle addr_pins", ap7, 4'h0);

        // DELAY=0: no WAIT cycles.
        req0 = 1'b1; addr0 = 16'hFFFF;
        txn(0, 16'hFFFF, 16'h0000, 1'b0, 16'h0, "d0_ffff");
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'h5A3C;
        txn(0, 16'h5A3C, 16'h1357, 1'b0, 16'h0, "d0_5a3c");

        // req held high: second START directly follows the first response.
        @(negedge clk);
        req7 = 1'b1; addr7 = 16'h0001;
        txn(7, 16'h0001, 16'h2468, 1'b1, 16'h0002, "b2b_0001");
        txn(7, 16'h0002, 16'h9ACE, 1'b0, 16'h0, "b2b_0002");

        // Reset pulse during WAIT abandons the read.
        @(negedge clk);
        req7 = 1'b1; addr7 = 16'hABCD;
        @(posedge clk);
        #1 req7 = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset ready", rdy7, 1);
        check("midreset rsp_valid", rv7, 0);
        check("midreset rsp_data", rd7, 16'h0000);
        check("midreset addr_pins", ap7, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rv7) saw = 1'b1;
        end
        check("no rsp_valid after reset", saw, 0);

        req7 = 1'b1; addr7 = 16'h0010;
        txn(7, 16'h0010, 16'h3C5A, 1'b0, 16'h0, "d7_0010");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
